// File: rtl/counter_bank_pkg.sv
// Shared types for the counter bank: per-channel operation
// selection and the priority decode that chooses it.
package counter_bank_pkg;

    typedef enum logic [2:0] {
        OP_NONE,
        OP_CLEAR,
        OP_LOAD,
        OP_INC,
        OP_DEC
    } op_e;

    // clear > load > (up xor down) > auto tick; up&down cancels
    // everything below it, including the auto tick.
    function automatic op_e decode_op(
        input logic clear,
        input logic load,
        input logic up,
        input logic down,
        input logic auto_tick
    );
        op_e op;
        if (clear) begin
            op = OP_CLEAR;
        end else if (load) begin
            op = OP_LOAD;
        end else if (up & down) begin
            op = OP_NONE;
        end else if (up) begin
            op = OP_INC;
        end else if (down) begin
            op = OP_DEC;
        end else if (auto_tick) begin
            op = OP_INC;
        end else begin
            op = OP_NONE;
        end
        return op;
    endfunction

endpackage

// File: rtl/counter_bank_channel.sv
// One counter channel: up/down/load/clear with wrap or saturate,
// sticky over/underflow, registered zero and compare-hit flags.
module cb_channel
    import counter_bank_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             enable,
    input  logic             saturate,
    input  logic             up,
    input  logic             down,
    input  logic             load,
    input  logic             tick,
    input  logic [WIDTH-1:0] load_val,
    input  logic [WIDTH-1:0] cmp_val,
    output logic [WIDTH-1:0] count,
    output logic             eq_zero,
    output logic             cmp_hit,
    output logic             ovf,
    output logic             unf
);

    localparam logic [WIDTH-1:0] MAX = '1;
    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    op_e  op;
    logic match;
    logic match_q;

    assign op    = decode_op(clear, load, up, down, enable & tick);
    assign match = (count == cmp_val);

    // Count update, sticky flags, and the one-edge-later status flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count   <= '0;
            ovf     <= 1'b0;
            unf     <= 1'b0;
            eq_zero <= 1'b1;
            cmp_hit <= 1'b0;
            match_q <= 1'b0;
        end else begin
            eq_zero <= (count == '0);
            match_q <= match;
            cmp_hit <= match & ~match_q;
            unique case (op)
                OP_CLEAR: begin
                    count <= '0;
                    ovf   <= 1'b0;
                    unf   <= 1'b0;
                end
                OP_LOAD: begin
                    count <= load_val;
                end
                OP_INC: begin
                    if (count == MAX) begin
                        ovf <= 1'b1;
                        if (!saturate) count <= '0;
                    end else begin
                        count <= count + ONE;
                    end
                end
                OP_DEC: begin
                    if (count == '0) begin
                        unf <= 1'b1;
                        if (!saturate) count <= MAX;
                    end else begin
                        count <= count - ONE;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: rtl/counter_bank.sv
// Bank of N_CH up/down counters sharing one prescaled tick,
// controlled from host endpoints synchronous to clk.
module counter_bank
    import counter_bank_pkg::*;
#(
    parameter int N_CH      = 4,
    parameter int WIDTH     = 8,
    parameter int DIV_WIDTH = 24,
    parameter logic [DIV_WIDTH-1:0] DIV_RELOAD = 24'h400000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [N_CH-1:0]       ch_clear,
    input  logic [N_CH-1:0]       ch_enable,
    input  logic [N_CH-1:0]       ch_saturate,
    input  logic [N_CH-1:0]       ch_up,
    input  logic [N_CH-1:0]       ch_down,
    input  logic [N_CH-1:0]       ch_load,
    input  logic [N_CH*WIDTH-1:0] load_val,
    input  logic [N_CH*WIDTH-1:0] cmp_val,
    output logic [N_CH*WIDTH-1:0] count,
    output logic [N_CH-1:0]       eq_zero,
    output logic [N_CH-1:0]       cmp_hit,
    output logic [N_CH-1:0]       ovf,
    output logic [N_CH-1:0]       unf,
    output logic                  tick
);

    localparam logic [DIV_WIDTH-1:0] DIV_ONE =
        {{(DIV_WIDTH-1){1'b0}}, 1'b1};

    logic [DIV_WIDTH-1:0] presc;

    // Down-counting prescaler; tick is registered the cycle after 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc <= DIV_RELOAD;
            tick  <= 1'b0;
        end else if (presc == '0) begin
            presc <= DIV_RELOAD;
            tick  <= 1'b1;
        end else begin
            presc <= presc - DIV_ONE;
            tick  <= 1'b0;
        end
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        cb_channel #(
            .WIDTH(WIDTH)
        ) u_ch (
            .clk      (clk),
            .reset    (reset),
            .clear    (ch_clear[i]),
            .enable   (ch_enable[i]),
            .saturate (ch_saturate[i]),
            .up       (ch_up[i]),
            .down     (ch_down[i]),
            .load     (ch_load[i]),
            .tick     (tick),
            .load_val (load_val[i*WIDTH +: WIDTH]),
            .cmp_val  (cmp_val[i*WIDTH +: WIDTH]),
            .count    (count[i*WIDTH +: WIDTH]),
            .eq_zero  (eq_zero[i]),
            .cmp_hit  (cmp_hit[i]),
            .ovf      (ovf[i]),
            .unf      (unf[i])
        );
    end

endmodule

// File: tb/tb_counter_bank.sv
// Self-checking bench for counter_bank (N_CH=2, WIDTH=8, DIV_RELOAD=3)
// using a queue of expected per-cycle results.
module tb_counter_bank;

    localparam int N_CH = 2;
    localparam int W    = 8;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [N_CH-1:0] ch_clear = '0;
    logic [N_CH-1:0] ch_enable = '0;
    logic [N_CH-1:0] ch_saturate = '0;
    logic [N_CH-1:0] ch_up = '0;
    logic [N_CH-1:0] ch_down = '0;
    logic [N_CH-1:0] ch_load = '0;
    logic [N_CH*W-1:0] load_val = '0;
    logic [N_CH*W-1:0] cmp_val = {8'h80, 8'h80};
    logic [N_CH*W-1:0] count;
    logic [N_CH-1:0] eq_zero;
    logic [N_CH-1:0] cmp_hit;
    logic [N_CH-1:0] ovf;
    logic [N_CH-1:0] unf;
    logic            tick;

    int n_cmp = 0;
    int n_bad = 0;

    counter_bank #(
        .N_CH(N_CH),
        .WIDTH(W),
        .DIV_WIDTH(24),
        .DIV_RELOAD(24'd3)
    ) dut (
        .clk(clk),
        .reset(reset),
        .ch_clear(ch_clear),
        .ch_enable(ch_enable),
        .ch_saturate(ch_saturate),
        .ch_up(ch_up),
        .ch_down(ch_down),
        .ch_load(ch_load),
        .load_val(load_val),
        .cmp_val(cmp_val),
        .count(count),
        .eq_zero(eq_zero),
        .cmp_hit(cmp_hit),
        .ovf(ovf),
        .unf(unf),
        .tick(tick)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic clr, ld, up, dn, sat;
        logic [7:0] lv, cv, cnt;
        logic ovf, unf, hit;
    } op_t;

    typedef struct {
        int ch;
        logic [7:0] cnt;
        logic ovf, unf, hit;
    } sb_t;

    typedef struct {
        logic tick;
        logic [7:0] c0, c1;
        logic [1:0] eq;
    } auto_t;

    sb_t   sb_q[$];
    auto_t auto_q[$];

    function automatic op_t mk(
        input logic clr, input logic ld, input logic up,
        input logic dn, input logic sat,
        input logic [7:0] lv, input logic [7:0] cv,
        input logic [7:0] cnt,
        input logic o, input logic u, input logic h
    );
        op_t r;
        r.clr = clr; r.ld = ld; r.up = up; r.dn = dn; r.sat = sat;
        r.lv = lv; r.cv = cv; r.cnt = cnt;
        r.ovf = o; r.unf = u; r.hit = h;
        return r;
    endfunction

    // Apply one cycle of stimulus to a channel and queue its expectation.
    task automatic drive_op(input int ch, input op_t op);
        sb_t e;
        ch_clear = '0; ch_load = '0; ch_up = '0; ch_down = '0;
        ch_clear[ch] = op.clr;
        ch_load[ch] = op.ld;
        ch_up[ch] = op.up;
        ch_down[ch] = op.dn;
        ch_saturate[ch] = op.sat;
        load_val[ch*W +: W] = op.lv;
        cmp_val[ch*W +: W] = op.cv;
        e.ch = ch; e.cnt = op.cnt;
        e.ovf = op.ovf; e.unf = op.unf; e.hit = op.hit;
        sb_q.push_back(e);
        @(posedge clk); #1;
        ch_clear = '0; ch_load = '0; ch_up = '0; ch_down = '0;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if (count !== 16'h0000 || eq_zero !== 2'b11 || cmp_hit !== 2'b00
            || ovf !== 2'b00 || unf !== 2'b00 || tick !== 1'b0) begin
            n_bad++;
            $display("FAIL reset: cnt=%h eq=%b hit=%b ovf=%b unf=%b tick=%b",
                     count, eq_zero, cmp_hit, ovf, unf, tick);
        end
        reset = 1'b0;
    endtask

    task automatic test_auto();
        auto_t a, e;
        ch_enable = 2'b01;
        for (int k = 1; k <= 13; k++) begin
            a.tick = (k % 4 == 0);
            a.c0 = 8'((k - 1) / 4);
            a.c1 = 8'h00;
            a.eq = {1'b1, (k <= 5)};
            auto_q.push_back(a);
            @(posedge clk); #1;
            e = auto_q.pop_front();
            n_cmp++;
            if (tick !== e.tick || count[7:0] !== e.c0
                || count[15:8] !== e.c1 || eq_zero !== e.eq) begin
                n_bad++;
                $display("FAIL auto edge%0d: tick=%b c0=%h c1=%h eq=%b, want %b %h %h %b",
                         k, tick, count[7:0], count[15:8], eq_zero,
                         e.tick, e.c0, e.c1, e.eq);
            end
        end
        ch_enable = 2'b00;
    endtask

    task automatic test_wrap_sat();
        op_t ops[$];
        sb_t e;
        ops.push_back(mk(1,0,0,0,0, 8'h00, 8'h80, 8'h00, 0,0,0));
        ops.push_back(mk(0,1,0,0,0, 8'hFE, 8'h80, 8'hFE, 0,0,0));
        ops.push_back(mk(0,0,1,0,0, 8'h00, 8'h80, 8'hFF, 0,0,0));
        ops.push_back(mk(0,0,1,0,0, 8'h00, 8'h80, 8'h00, 1,0,0));
        ops.push_back(mk(0,0,0,0,0, 8'h00, 8'h80, 8'h00, 1,0,0));
        ops.push_back(mk(1,0,0,0,1, 8'h00, 8'h80, 8'h00, 0,0,0));
        ops.push_back(mk(0,1,0,0,1, 8'hFE, 8'h80, 8'hFE, 0,0,0));
        ops.push_back(mk(0,0,1,0,1, 8'h00, 8'h80, 8'hFF, 0,0,0));
        ops.push_back(mk(0,0,1,0,1, 8'h00, 8'h80, 8'hFF, 1,0,0));
        ops.push_back(mk(0,0,0,0,1, 8'h00, 8'h80, 8'hFF, 1,0,0));
        foreach (ops[i]) begin
            drive_op(0, ops[i]);
            e = sb_q.pop_front();
            n_cmp++;
            if (count[e.ch*W +: W] !== e.cnt || ovf[e.ch] !== e.ovf
                || unf[e.ch] !== e.unf || cmp_hit[e.ch] !== e.hit) begin
                n_bad++;
                $display("FAIL wrap_sat step%0d: cnt=%h ovf=%b unf=%b hit=%b, want %h %b %b %b",
                         i, count[e.ch*W +: W], ovf[e.ch], unf[e.ch],
                         cmp_hit[e.ch], e.cnt, e.ovf, e.unf, e.hit);
            end
        end
    endtask

    task automatic test_underflow();
        op_t ops[$];
        sb_t e;
        ops.push_back(mk(0,0,0,1,0, 8'h00, 8'h80, 8'hFF, 0,1,0));
        ops.push_back(mk(0,0,0,0,0, 8'h00, 8'h80, 8'hFF, 0,1,0));
        ops.push_back(mk(1,0,0,0,0, 8'h00, 8'h80, 8'h00, 0,0,0));
        ops.push_back(mk(0,0,0,1,1, 8'h00, 8'h80, 8'h00, 0,1,0));
        ops.push_back(mk(1,0,0,0,0, 8'h00, 8'h80, 8'h00, 0,0,0));
        foreach (ops[i]) begin
            drive_op(1, ops[i]);
            e = sb_q.pop_front();
            n_cmp++;
            if (count[e.ch*W +: W] !== e.cnt || ovf[e.ch] !== e.ovf
                || unf[e.ch] !== e.unf || cmp_hit[e.ch] !== e.hit) begin
                n_bad++;
                $display("FAIL underflow step%0d: cnt=%h ovf=%b unf=%b hit=%b, want %h %b %b %b",
                         i, count[e.ch*W +: W], ovf[e.ch], unf[e.ch],
                         cmp_hit[e.ch], e.cnt, e.ovf, e.unf, e.hit);
            end
        end
    endtask

    task automatic test_compare();
        op_t ops[$];
        sb_t e;
        ops.push_back(mk(1,0,0,0,0, 8'h00, 8'h05, 8'h00, 0,0,0));
        ops.push_back(mk(0,0,1,0,0, 8'h00, 8'h05, 8'h01, 0,0,0));
        ops.push_back(mk(0,0,1,0,0, 8'h00, 8'h05, 8'h02, 0,0,0));
        ops.push_back(mk(0,0,1,0,0, 8'h00, 8'h05, 8'h03, 0,0,0));
        ops.push_back(mk(0,0,1,0,0, 8'h00, 8'h05, 8'h04, 0,0,0));
        ops.push_back(mk(0,0,1,0,0, 8'h00, 8'h05, 8'h05, 0,0,0));
        ops.push_back(mk(0,0,0,0,0, 8'h00, 8'h05, 8'h05, 0,0,1));
        ops.push_back(mk(0,0,0,0,0, 8'h00, 8'h05, 8'h05, 0,0,0));
        ops.push_back(mk(0,0,0,0,0, 8'h00, 8'h05, 8'h05, 0,0,0));
        ops.push_back(mk(0,0,0,0,0, 8'h00, 8'h07, 8'h05, 0,0,0));
        ops.push_back(mk(0,0,0,0,0, 8'h00, 8'h05, 8'h05, 0,0,1));
        ops.push_back(mk(0,0,0,0,0, 8'h00, 8'h05, 8'h05, 0,0,0));
        foreach (ops[i]) begin
            drive_op(0, ops[i]);
            e = sb_q.pop_front();
            n_cmp++;
            if (count[e.ch*W +: W] !== e.cnt || ovf[e.ch] !== e.ovf
                || unf[e.ch] !== e.unf || cmp_hit[e.ch] !== e.hit) begin
                n_bad++;
                $display("FAIL compare step%0d: cnt=%h ovf=%b unf=%b hit=%b, want %h %b %b %b",
                         i, count[e.ch*W +: W], ovf[e.ch], unf[e.ch],
                         cmp_hit[e.ch], e.cnt, e.ovf, e.unf, e.hit);
            end
            if (i == 0 || i == 1) begin
                n_cmp++;
                if (eq_zero[0] !== (i == 1)) begin
                    n_bad++;
                    $display("FAIL eq_zero step%0d: got %b want %b",
                             i, eq_zero[0], (i == 1));
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        op_t ops[$];
        sb_t e;
        int  k;
        k = 0;
        while (tick !== 1'b1 && k < 8) begin
            @(posedge clk); #1;
            k++;
        end
        n_cmp++;
        if (tick !== 1'b1) begin
            n_bad++;
            $display("FAIL cancel_wait: tick=%b want 1", tick);
        end
        ch_enable = 2'b01;
        ops.push_back(mk(0,0,1,1,0, 8'h00, 8'h05, 8'h05, 0,0,0));
        ops.push_back(mk(1,1,0,0,0, 8'hFE, 8'h05, 8'h00, 0,0,0));
        foreach (ops[i]) begin
            drive_op(0, ops[i]);
            ch_enable = 2'b00;
            e = sb_q.pop_front();
            n_cmp++;
            if (count[e.ch*W +: W] !== e.cnt || ovf[e.ch] !== e.ovf
                || unf[e.ch] !== e.unf || cmp_hit[e.ch] !== e.hit) begin
                n_bad++;
                $display("FAIL back_to_back step%0d: cnt=%h ovf=%b unf=%b hit=%b, want %h %b %b %b",
                         i, count[e.ch*W +: W], ovf[e.ch], unf[e.ch],
                         cmp_hit[e.ch], e.cnt, e.ovf, e.unf, e.hit);
            end
        end
    endtask

    task automatic test_reset_mid();
        sb_t e;
        int  k;
        int  chs[2];
        op_t ops[2];
        k = 0;
        while (tick !== 1'b1 && k < 8) begin
            @(posedge clk); #1;
            k++;
        end
        n_cmp++;
        if (tick !== 1'b1) begin
            n_bad++;
            $display("FAIL mid_wait: tick=%b want 1", tick);
        end
        chs[0] = 0;
        ops[0] = mk(0,1,0,0,0, 8'h37, 8'h05, 8'h37, 0,0,0);
        chs[1] = 1;
        ops[1] = mk(0,0,0,1,0, 8'h00, 8'h80, 8'hFF, 0,1,0);
        for (int i = 0; i < 2; i++) begin
            drive_op(chs[i], ops[i]);
            e = sb_q.pop_front();
            n_cmp++;
            if (count[e.ch*W +: W] !== e.cnt || ovf[e.ch] !== e.ovf
                || unf[e.ch] !== e.unf || cmp_hit[e.ch] !== e.hit) begin
                n_bad++;
                $display("FAIL mid_setup step%0d: cnt=%h ovf=%b unf=%b hit=%b, want %h %b %b %b",
                         i, count[e.ch*W +: W], ovf[e.ch], unf[e.ch],
                         cmp_hit[e.ch], e.cnt, e.ovf, e.unf, e.hit);
            end
        end
        reset = 1'b1;
        #2;
        n_cmp++;
        if (count !== 16'h0000 || eq_zero !== 2'b11 || cmp_hit !== 2'b00
            || ovf !== 2'b00 || unf !== 2'b00 || tick !== 1'b0) begin
            n_bad++;
            $display("FAIL mid_reset: cnt=%h eq=%b hit=%b ovf=%b unf=%b tick=%b",
                     count, eq_zero, cmp_hit, ovf, unf, tick);
        end
        #2;
        reset = 1'b0;
        for (int j = 1; j <= 5; j++) begin
            @(posedge clk); #1;
            n_cmp++;
            if (tick !== (j == 4)) begin
                n_bad++;
                $display("FAIL restart_tick edge%0d: got %b want %b",
                         j, tick, (j == 4));
            end
        end
    endtask

    initial begin
        test_reset();
        test_auto();
        test_wrap_sat();
        test_underflow();
        test_compare();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
